// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencing controller.
package mdu_ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 4;
  localparam int unsigned CNTW = 4;

  localparam logic [OPW-1:0] MD_NONE  = 4'd0;
  localparam logic [OPW-1:0] MD_MULT  = 4'd1;
  localparam logic [OPW-1:0] MD_MULTU = 4'd2;
  localparam logic [OPW-1:0] MD_DIV   = 4'd3;
  localparam logic [OPW-1:0] MD_DIVU  = 4'd4;
  localparam logic [OPW-1:0] MD_MFHI  = 4'd5;
  localparam logic [OPW-1:0] MD_MFLO  = 4'd6;
  localparam logic [OPW-1:0] MD_MTHI  = 4'd7;
  localparam logic [OPW-1:0] MD_MTLO  = 4'd8;

  typedef enum logic {
    MDS_IDLE = 1'b0,
    MDS_BUSY = 1'b1
  } mds_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            div_zero;
  } md_res_t;

  // Operations that occupy the unit for a multi-cycle busy period.
  function automatic logic is_arith(input logic [OPW-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Any defined MD-class op; undefined codes behave as MD_NONE.
  function automatic logic is_md(input logic [OPW-1:0] op);
    return (op >= MD_MULT) && (op <= MD_MTLO);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the {hi, lo} pair for one op.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [OPW-1:0]  op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output md_res_t         res_o
);

  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0] prod_u;
  logic              sdiv;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   q_mag;
  logic [XLEN-1:0]   r_mag;

  // Signed division works on magnitudes so the INT_MIN / -1 case wraps cleanly.
  always_comb begin
    res_o  = '0;
    prod_s = {{XLEN{a_i[XLEN-1]}}, a_i} * {{XLEN{b_i[XLEN-1]}}, b_i};
    prod_u = {{XLEN{1'b0}}, a_i} * {{XLEN{1'b0}}, b_i};
    sdiv   = (op_i == MD_DIV);
    a_neg  = sdiv & a_i[XLEN-1];
    b_neg  = sdiv & b_i[XLEN-1];
    a_mag  = a_neg ? (~a_i + XLEN'(1)) : a_i;
    b_mag  = b_neg ? (~b_i + XLEN'(1)) : b_i;
    q_mag  = '0;
    r_mag  = '0;
    if (b_mag != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end

    case (op_i)
      MD_MULT:  {res_o.hi, res_o.lo} = prod_s;
      MD_MULTU: {res_o.hi, res_o.lo} = prod_u;
      MD_DIV, MD_DIVU: begin
        if (b_i == '0) begin
          res_o.div_zero = 1'b1;
        end else begin
          res_o.lo = (a_neg ^ b_neg) ? (~q_mag + XLEN'(1)) : q_mag;
          res_o.hi = a_neg ? (~r_mag + XLEN'(1)) : r_mag;
        end
      end
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencing controller: fixed-latency busy period, HI/LO ownership, D-stage stall.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            md_valid_e,
  input  logic [OPW-1:0]  md_op_e,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [OPW-1:0]  md_op_d,
  output logic            busy,
  output logic            stall_md,
  output logic [XLEN-1:0] md_rdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  mds_e            state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] pend_hi_q, pend_hi_d;
  logic [XLEN-1:0] pend_lo_q, pend_lo_d;
  logic            pend_wr_q, pend_wr_d;
  logic            start_c;
  md_res_t         arith_res;

  mdu_arith u_arith (
    .op_i  (md_op_e),
    .a_i   (src_a),
    .b_i   (src_b),
    .res_o (arith_res)
  );

  assign start_c = md_valid_e && (state_q == MDS_IDLE) && is_arith(md_op_e);

  // State register and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= MDS_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // Next-state: E-stage ops are only accepted while idle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    case (state_q)
      MDS_IDLE: begin
        if (start_c) begin
          pend_hi_d = arith_res.hi;
          pend_lo_d = arith_res.lo;
          pend_wr_d = !arith_res.div_zero;
          cnt_d     = ((md_op_e == MD_DIV) || (md_op_e == MD_DIVU)) ?
                      CNTW'(DIV_CYCLES) : CNTW'(MULT_CYCLES);
          state_d   = MDS_BUSY;
        end else if (md_valid_e && (md_op_e == MD_MTHI)) begin
          hi_d = src_a;
        end else if (md_valid_e && (md_op_e == MD_MTLO)) begin
          lo_d = src_a;
        end
      end
      MDS_BUSY: begin
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d = MDS_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = MDS_IDLE;
    endcase
  end

  assign busy     = (state_q == MDS_BUSY);
  assign stall_md = is_md(md_op_d) && (busy || start_c);
  assign md_rdata = (md_op_e == MD_MFHI) ? hi_q :
                    (md_op_e == MD_MFLO) ? lo_q : '0;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with an arithmetic reference model checked every cycle.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        md_valid_e;
  logic [3:0]  md_op_e;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [3:0]  md_op_d;
  logic        busy;
  logic        stall_md;
  logic [31:0] md_rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .md_valid_e (md_valid_e),
    .md_op_e    (md_op_e),
    .src_a      (src_a),
    .src_b      (src_b),
    .md_op_d    (md_op_d),
    .busy       (busy),
    .stall_md   (stall_md),
    .md_rdata   (md_rdata),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: {write_enable, hi, lo} using 64-bit integer math.
  function automatic logic [64:0] model_arith(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      MD_MULT:  begin p = 64'(sa * sb); return {1'b1, p}; end
      MD_MULTU: begin p = ua * ub; return {1'b1, p}; end
      MD_DIV: begin
        if (b == 32'h0) return {1'b0, 64'h0};
        q = sa / sb;
        r = sa % sb;
        return {1'b1, 32'(r), 32'(q)};
      end
      MD_DIVU: begin
        if (b == 32'h0) return {1'b0, 64'h0};
        return {1'b1, 32'(ua % ub), 32'(ua / ub)};
      end
      default: return {1'b0, 64'h0};
    endcase
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  logic        m_pwr = 1'b0;
  int          m_rem = 0;
  logic [64:0] m_res;

  assign m_res = model_arith(md_op_e, src_a, src_b);

  // Model: busy for N edges after accepting an arithmetic op, results land on the last.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi <= '0; m_lo <= '0; m_phi <= '0; m_plo <= '0; m_pwr <= 1'b0; m_rem <= 0;
    end else if (m_rem > 0) begin
      if (m_rem == 1 && m_pwr) begin
        m_hi <= m_phi;
        m_lo <= m_plo;
      end
      m_rem <= m_rem - 1;
    end else if (md_valid_e) begin
      if (md_op_e inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) begin
        m_pwr <= m_res[64];
        m_phi <= m_res[63:32];
        m_plo <= m_res[31:0];
        m_rem <= (md_op_e inside {MD_DIV, MD_DIVU}) ? int'(DIV_N) : int'(MULT_N);
      end else if (md_op_e == MD_MTHI) begin
        m_hi <= src_a;
      end else if (md_op_e == MD_MTLO) begin
        m_lo <= src_a;
      end
    end
  end

  logic        e_busy, e_start, e_stall;
  logic [31:0] e_rdata;

  always @(negedge clk) begin
    if (chk_en) begin
      e_busy  = (m_rem != 0);
      e_start = md_valid_e && !e_busy && (md_op_e inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU});
      e_stall = (md_op_d >= 4'd1 && md_op_d <= 4'd8) && (e_busy || e_start);
      e_rdata = (md_op_e == MD_MFHI) ? m_hi : (md_op_e == MD_MFLO) ? m_lo : 32'h0;
      check("busy", 32'(busy), 32'(e_busy));
      check("stall_md", 32'(stall_md), 32'(e_stall));
      check("md_rdata", md_rdata, e_rdata);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single cycle, checking the start-cycle stall when it matters.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    md_valid_e = 1'b1;
    md_op_e    = op;
    src_a      = a;
    src_b      = b;
    @(negedge clk);
    if (md_op_d != MD_NONE && is_arith(op)) check("stall_start", 32'(stall_md), 32'h1);
    step();
    md_valid_e = 1'b0;
    md_op_e    = MD_NONE;
  endtask

  task automatic wait_idle(input string name, input int exp_cycles);
    int n    = 0;
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (busy) begin
        n++;
        check({name, "_stall"}, 32'(stall_md), 32'(md_op_d != MD_NONE));
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: busy still %b after 40 cycles, required 0", name, busy);
    end
    check({name, "_cycles"}, 32'(n), 32'(exp_cycles));
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    issue(op, a, b);
    wait_idle(name, n);
    check({name, "_hi"}, hi, exp_hi);
    check({name, "_lo"}, lo, exp_lo);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    md_valid_e = 1'b0;
    md_op_e    = MD_NONE;
    src_a      = '0;
    src_b      = '0;
    md_op_d    = MD_NONE;
    repeat (2) step();
    reset_n = 1'b1;
    chk_en  = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    step();

    run_op("mult", MD_MULT, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    md_op_d = MD_MFLO;
    run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
    md_op_d = MD_NONE;
    run_op("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu0", MD_DIVU, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divmin", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
    run_op("divneg", MD_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu", MD_DIVU, 32'd100, 32'd7, 10, 32'h00000002, 32'h0000000E);

    // Invalid E-stage op must be inert.
    md_op_e = MD_MULT; src_a = 32'd5; src_b = 32'd5;
    repeat (3) step();
    check("novalid_busy", 32'(busy), 32'h0);
    check("novalid_hi", hi, 32'h00000002);
    check("novalid_lo", lo, 32'h0000000E);
    md_op_e = MD_NONE;

    // Undefined op codes behave as MD_NONE in both stages.
    md_valid_e = 1'b1; md_op_e = 4'hF; md_op_d = 4'hF;
    @(negedge clk);
    check("undef_stall", 32'(stall_md), 32'h0);
    check("undef_rdata", md_rdata, 32'h0);
    step();
    md_valid_e = 1'b0; md_op_e = MD_NONE; md_op_d = MD_NONE;
    @(negedge clk);
    check("undef_busy", 32'(busy), 32'h0);
    step();

    issue(MD_MTHI, 32'h12345678, 32'h0);
    md_valid_e = 1'b1; md_op_e = MD_MFHI;
    @(negedge clk);
    check("mfhi_rdata", md_rdata, 32'h12345678);
    check("mthi_busy", 32'(busy), 32'h0);
    step();
    md_valid_e = 1'b0; md_op_e = MD_NONE;
    issue(MD_MTLO, 32'h9ABCDEF0, 32'h0);
    md_valid_e = 1'b1; md_op_e = MD_MFLO;
    @(negedge clk);
    check("mflo_rdata", md_rdata, 32'h9ABCDEF0);
    check("mflo_hi", hi, 32'h12345678);
    step();
    md_valid_e = 1'b0; md_op_e = MD_NONE;

    // Reset in the third busy cycle of a divide drops the pending result.
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (2) step();
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    step();
    reset_n = 1'b1;
    repeat (15) step();
    check("postrst_hi", hi, 32'h0);
    check("postrst_lo", lo, 32'h0);
    check("postrst_busy", 32'(busy), 32'h0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Sequencing controller for the multiply/divide unit added to the five-stage pipeline. It accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo operations from the E stage and models fixed multi-cycle latency with a busy counter. It owns the HI/LO registers and raises a stall request toward the hazard unit whenever a D-stage MD-class instruction would observe an in-flight operation.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
md_valid_e  input  1  E-stage instruction valid (low on bubble/flush)
md_op_e  input  4  E-stage MD operation code (package encoding)
src_a  input  32  E-stage forwarded rs value
src_b  input  32  E-stage forwarded rt value
md_op_d  input  4  D-stage MD operation code, used for the stall decision
busy  output  1  multi-cycle operation in flight
stall_md  output  1  stall request to the hazard unit
md_rdata  output  32  mfhi/mflo result for the E-stage write-back mux
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (async, reset_n=0): hi=0, lo=0, busy=0, counter=0, state=IDLE, pending result=0. Reset mid-operation discards the pending result.
- States:
  - IDLE → BUSY on start.
  - BUSY → IDLE when counter==1 at a rising edge.
- start = md_valid_e & state==IDLE & op in {MULT, MULTU, DIV, DIVU}.
- On start:
  - Latch the 64-bit result {hi_new, lo_new} from src_a/src_b into pending registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
- BUSY: counter decrements each cycle. At the edge where counter==1, write pending to hi/lo and go to IDLE.
- Latency: start in cycle t gives busy=1 in cycles t+1..t+N. hi/lo hold new values from cycle t+N+1, where busy=0.
- mult: signed 64-bit product, hi=[63:32], lo=[31:0].
- multu: unsigned 64-bit product, hi=[63:32], lo=[31:0].
- div/divu: lo=quotient, hi=remainder (signed or unsigned). Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero: the full DIV_CYCLES busy period still runs; hi/lo are left unchanged at completion.
- Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi/mtlo (md_valid_e, IDLE): write src_a into hi/lo at the next edge. No busy.
- mfhi/mflo: md_rdata = hi or lo, combinational. md_rdata=0 for any other op.
- stall_md = (md_op_d != MD_NONE) & (busy | start).
- Illegal cases: an E-stage MD op while busy is ignored (the hazard unit guarantees it cannot occur). An undefined op code is treated as MD_NONE.
- md_valid_e=0: no state change regardless of md_op_e.

Decomposition:
- Shared package/header def.v holds:
  - MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MFHI=5, MD_MFLO=6, MD_MTHI=7, MD_MTLO=8
  - state encodings MDS_IDLE=0, MDS_BUSY=1
- One sub-module, mdu_arith: purely combinational. It takes (op, a, b) and produces {hi_new, lo_new, div_zero}. The controller registers its output.

Test Plan:
- mult a=0xFFFFFFFE (-2), b=3 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu a=0xFFFFFFFF, b=2 → after 5 cycles hi=0x00000001, lo=0xFFFFFFFE. stall_md=1 in the start cycle and all busy cycles while md_op_d=MD_MFLO.
- div a=0xFFFFFFF9 (-7), b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=0 → busy 10 cycles, hi/lo unchanged.
- mthi src_a=0x12345678, then mfhi next cycle → md_rdata=0x12345678, busy never asserted.
- Assert reset_n=0 in cycle 3 of a div → busy=0, hi=lo=0 immediately; no write when reset_n releases.
- md_valid_e=0 with md_op_e=MD_MULT → no busy, hi/lo unchanged. md_op_d=MD_NONE while busy → stall_md=0.
